// File: rtl/score_if.sv
// -----------------------------------------------------------------------------
// score_if: bundles the request inputs and display/score outputs of the snake
// game score controller.
//   master modport: drives start/apple/bonus/game_over requests and observes
//                   the score, high score, FSM state and BCD display digits.
//   slave modport : the score controller itself.
// -----------------------------------------------------------------------------
interface score_if;
  logic       start_i;
  logic       apple_hit_i;
  logic       bonus_hit_i;
  logic       game_over_i;
  logic [6:0] score_o;
  logic [6:0] high_score_o;
  logic [1:0] state_o;
  logic [3:0] tens_o;
  logic [3:0] units_o;
  logic       bcd_valid_o;
  logic       show_high_o;
  logic       new_record_o;

  modport master (
    output start_i, apple_hit_i, bonus_hit_i, game_over_i,
    input  score_o, high_score_o, state_o, tens_o, units_o,
           bcd_valid_o, show_high_o, new_record_o
  );

  modport slave (
    input  start_i, apple_hit_i, bonus_hit_i, game_over_i,
    output score_o, high_score_o, state_o, tens_o, units_o,
           bcd_valid_o, show_high_o, new_record_o
  );
endinterface

// File: rtl/score_ctrl.sv
// -----------------------------------------------------------------------------
// score_ctrl: game-score controller for the snake game.
//   Sequences IDLE -> PLAY -> OVER, turns apple/bonus hit edges into a single
//   saturating score, keeps the best score since reset, and converts the
//   currently displayed value to BCD with a repeated-subtraction converter.
//
// Ports:
//   clk_i      system clock
//   reset_ni   asynchronous reset, active-low
//   bus        score_if.slave: request inputs (start, apple, bonus, game_over;
//              all levels, rising edge acts) and outputs (score, high score,
//              state 00 IDLE / 01 PLAY / 10 OVER, BCD tens/units, bcd_valid,
//              show_high, new_record)
//
// Optional feature macro: BONUS_SCORE_EN
//   defined   : bonus_hit_i edges add BONUS_PTS
//   undefined : bonus_hit_i is ignored (port kept, edge register omitted)
// -----------------------------------------------------------------------------
module score_ctrl #(
  parameter int unsigned MAX_SCORE    = 99,
  parameter int unsigned APPLE_PTS    = 1,
  parameter int unsigned BONUS_PTS    = 5,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input logic    clk_i,
  input logic    reset_ni,
  score_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [7:0] MAX8   = 8'(MAX_SCORE);
  localparam logic [6:0] MAX7   = 7'(MAX_SCORE);
  localparam logic [7:0] APPLE8 = 8'(APPLE_PTS);
  localparam logic [7:0] BONUS8 = 8'(BONUS_PTS);

  state_e               state_q, state_d;
  logic [6:0]           score_q, score_d;
  logic [6:0]           high_q, high_d;
  logic                 rec_q, rec_d;
  logic                 phase_q, phase_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;

  // ---------------------------------------------------------------------------
  // Edge detection: each request is registered once; event = level & ~prev.
  // ---------------------------------------------------------------------------
  logic start_prev_q, apple_prev_q, over_prev_q;
  logic start_ev, apple_ev, bonus_ev, over_ev;

  // NOTE: sequential state is written with non-blocking (<=) so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      start_prev_q <= 1'b0;
      apple_prev_q <= 1'b0;
      over_prev_q  <= 1'b0;
    end else begin
      start_prev_q <= bus.start_i;
      apple_prev_q <= bus.apple_hit_i;
      over_prev_q  <= bus.game_over_i;
    end
  end

  assign start_ev = bus.start_i     & ~start_prev_q;
  assign apple_ev = bus.apple_hit_i & ~apple_prev_q;
  assign over_ev  = bus.game_over_i & ~over_prev_q;

`ifdef BONUS_SCORE_EN
  logic bonus_prev_q;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) bonus_prev_q <= 1'b0;
    else           bonus_prev_q <= bus.bonus_hit_i;
  end
  assign bonus_ev = bus.bonus_hit_i & ~bonus_prev_q;
`else
  logic unused_bonus;
  assign unused_bonus = bus.bonus_hit_i;
  assign bonus_ev     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Score arithmetic: 8-bit sum so a near-ceiling score cannot wrap before
  // the saturation compare.
  // ---------------------------------------------------------------------------
  logic [7:0] hit_pts;
  logic [7:0] score_sum;
  logic [6:0] score_sat;

  always_comb begin
    hit_pts = 8'd0;
    if (apple_ev) hit_pts = hit_pts + APPLE8;
    if (bonus_ev) hit_pts = hit_pts + BONUS8;
  end

  assign score_sum = {1'b0, score_q} + hit_pts;
  assign score_sat = (score_sum > MAX8) ? MAX7 : score_sum[6:0];

  // ---------------------------------------------------------------------------
  // Game FSM and score/high-score/blink next-state logic.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    rec_d   = rec_q;
    blink_d = blink_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          state_d = ST_PLAY;
          score_d = '0;
          rec_d   = 1'b0;
        end
      end
      ST_PLAY: begin
        // game_over wins over a simultaneous hit: OVER keeps the pre-hit score
        if (over_ev) begin
          state_d = ST_OVER;
          blink_d = '0;
          phase_d = 1'b0;
          if (score_q > high_q) begin
            high_d = score_q;
            rec_d  = 1'b1;
          end
        end else if (apple_ev || bonus_ev) begin
          score_d = score_sat;
        end
      end
      ST_OVER: begin
        if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          phase_d = ~phase_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
        if (start_ev) begin
          state_d = ST_PLAY;
          score_d = '0;
          rec_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      high_q  <= '0;
      rec_q   <= 1'b0;
      blink_q <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      high_q  <= high_d;
      rec_q   <= rec_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display source selection.
  // ---------------------------------------------------------------------------
  logic       show_high;
  logic [6:0] disp_val;

  always_comb begin
    show_high = 1'b1;
    unique case (state_q)
      ST_PLAY: show_high = 1'b0;
      ST_OVER: show_high = phase_q;
      default: show_high = 1'b1;
    endcase
  end

  assign disp_val = show_high ? high_q : score_q;

  // ---------------------------------------------------------------------------
  // Binary-to-BCD by repeated subtraction of 10. A new source value (compared
  // with the last latched one) restarts the conversion, which also covers an
  // abort mid-conversion. tens/units hold the previous result while busy.
  // ---------------------------------------------------------------------------
  logic [6:0] last_q;
  logic [6:0] rem_q;
  logic [3:0] tens_acc_q;
  logic [3:0] tens_q;
  logic [3:0] units_q;
  logic       busy_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_q     <= '0;
      rem_q      <= '0;
      tens_acc_q <= '0;
      tens_q     <= '0;
      units_q    <= '0;
      busy_q     <= 1'b0;
    end else if (disp_val != last_q) begin
      last_q     <= disp_val;
      rem_q      <= disp_val;
      tens_acc_q <= '0;
      busy_q     <= 1'b1;
    end else if (busy_q) begin
      if (rem_q >= 7'd10) begin
        rem_q      <= rem_q - 7'd10;
        tens_acc_q <= tens_acc_q + 4'd1;
      end else begin
        tens_q  <= tens_acc_q;
        units_q <= rem_q[3:0];
        busy_q  <= 1'b0;
      end
    end
  end

  // Valid drops in the very cycle the source moves away from the latched value.
  assign bus.bcd_valid_o  = ~busy_q & (disp_val == last_q);
  assign bus.tens_o       = tens_q;
  assign bus.units_o      = units_q;
  assign bus.show_high_o  = show_high;
  assign bus.score_o      = score_q;
  assign bus.high_score_o = high_q;
  assign bus.state_o      = state_q;
  assign bus.new_record_o = rec_q;

endmodule

// File: tb/tb_score_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_ctrl: self-checking bench for score_ctrl (BLINK_CYCLES = 4).
// A behavioural model tracks game state, score, high score, blink phase (from
// cycles spent in OVER) and the expected BCD readiness (from cycles since the
// displayed value last changed); every cycle the outputs are compared to it.
// Directed sequences pin the model with literal expectations, then random
// request levels exercise the rest.
// -----------------------------------------------------------------------------
module tb_score_ctrl;

  localparam int MAX_SCORE = 99;
  localparam int APPLE_PTS = 1;
  localparam int BONUS_PTS = 5;
  localparam int BLINK     = 4;

`ifdef BONUS_SCORE_EN
  localparam int EXP_SMALL   = 8;
  localparam int EXP_SAT_HIT = 99;
`else
  localparam int EXP_SMALL   = 3;
  localparam int EXP_SAT_HIT = 97;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  score_if bus ();

  score_ctrl #(
    .MAX_SCORE   (MAX_SCORE),
    .APPLE_PTS   (APPLE_PTS),
    .BONUS_PTS   (BONUS_PTS),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: 0 IDLE, 1 PLAY, 2 OVER
  int m_state, m_score, m_high, m_over_cyc, m_disp, m_age;
  bit m_rec;
  bit p_s, p_a, p_b, p_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_disp();
    if (m_state == 0) return m_high;
    if (m_state == 1) return m_score;
    return (((m_over_cyc / BLINK) % 2) == 1) ? m_high : m_score;
  endfunction

  function automatic int model_show_high();
    if (m_state == 0) return 1;
    if (m_state == 1) return 0;
    return (m_over_cyc / BLINK) % 2;
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_high = 0; m_rec = 0; m_over_cyc = 0;
    m_disp = 0; m_age = 1000;
    p_s = 0; p_a = 0; p_b = 0; p_g = 0;
  endtask

  task automatic model_update(input bit s, input bit a, input bit b, input bit g);
    bit se, ae, be, ge;
    int pts, nd;
    se = s & ~p_s;
    ae = a & ~p_a;
    ge = g & ~p_g;
`ifdef BONUS_SCORE_EN
    be = b & ~p_b;
`else
    be = 1'b0 & b & ~p_b;
`endif
    p_s = s; p_a = a; p_b = b; p_g = g;
    pts = (ae ? APPLE_PTS : 0) + (be ? BONUS_PTS : 0);
    case (m_state)
      0: if (se) begin m_state = 1; m_score = 0; m_rec = 0; end
      1: begin
        if (ge) begin
          m_state = 2; m_over_cyc = 0;
          if (m_score > m_high) begin m_high = m_score; m_rec = 1; end
        end else if (pts > 0) begin
          m_score = (m_score + pts > MAX_SCORE) ? MAX_SCORE : m_score + pts;
        end
      end
      default: begin
        m_over_cyc++;
        if (se) begin m_state = 1; m_score = 0; m_rec = 0; end
      end
    endcase
    nd = model_disp();
    if (nd != m_disp) m_age = 0;
    else if (m_age < 1000) m_age++;
    m_disp = nd;
  endtask

  task automatic compare();
    bit exp_valid;
    exp_valid = (m_age >= m_disp / 10 + 2);
    check("state",      bus.state_o,      m_state);
    check("score",      bus.score_o,      m_score);
    check("high_score", bus.high_score_o, m_high);
    check("new_record", bus.new_record_o, m_rec);
    check("show_high",  bus.show_high_o,  model_show_high());
    check("bcd_valid",  bus.bcd_valid_o,  exp_valid);
    if (exp_valid) begin
      check("tens",  bus.tens_o,  m_disp / 10);
      check("units", bus.units_o, m_disp % 10);
    end
  endtask

  // One clock: drive levels, advance model at the edge, compare at negedge.
  task automatic tick(input bit s, input bit a, input bit b, input bit g);
    bus.start_i = s; bus.apple_hit_i = a; bus.bonus_hit_i = b; bus.game_over_i = g;
    @(posedge clk);
    model_update(s, a, b, g);
    @(negedge clk);
    compare();
  endtask

  task automatic start_p();  tick(1, 0, 0, 0); tick(0, 0, 0, 0); endtask
  task automatic apple_p();  tick(0, 1, 0, 0); tick(0, 0, 0, 0); endtask
  task automatic bonus_p();  tick(0, 0, 1, 0); tick(0, 0, 0, 0); endtask
  task automatic over_p();   tick(0, 0, 0, 1); tick(0, 0, 0, 0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) tick(0, 0, 0, 0); endtask

  task automatic play_game(input int n_apples);
    start_p();
    for (int i = 0; i < n_apples; i++) apple_p();
    over_p();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".state"},      bus.state_o,      0);
    check({tag, ".score"},      bus.score_o,      0);
    check({tag, ".high"},       bus.high_score_o, 0);
    check({tag, ".new_record"}, bus.new_record_o, 0);
    check({tag, ".tens"},       bus.tens_o,       0);
    check({tag, ".units"},      bus.units_o,      0);
    check({tag, ".bcd_valid"},  bus.bcd_valid_o,  1);
    check({tag, ".show_high"},  bus.show_high_o,  1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 0; bus.apple_hit_i = 0; bus.bonus_hit_i = 0; bus.game_over_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_reset_values("rst");

    // Start, then three apples and one bonus
    start_p();
    check("start.state", bus.state_o, 1);
    check("start.score", bus.score_o, 0);
    check("start.valid", bus.bcd_valid_o, 1);
    check("start.tens",  bus.tens_o, 0);
    check("start.units", bus.units_o, 0);
    apple_p(); apple_p(); bonus_p();
    tick(0, 1, 0, 0);
    check("hits.score",  bus.score_o, EXP_SMALL);
    check("hits.valid0", bus.bcd_valid_o, 0);
    tick(0, 0, 0, 0);
    check("hits.valid1", bus.bcd_valid_o, 0);
    tick(0, 0, 0, 0);
    check("hits.valid2", bus.bcd_valid_o, 1);
    check("hits.tens",   bus.tens_o, 0);
    check("hits.units",  bus.units_o, EXP_SMALL);

    // Saturation: apple + bonus together at 96
    while (m_score < 96) apple_p();
    tick(0, 1, 1, 0);
    check("sat.hit", bus.score_o, EXP_SAT_HIT);
    tick(0, 0, 0, 0);
    repeat (4) apple_p();
    check("sat.hold", bus.score_o, 99);
    idle(12);
    check("sat.valid", bus.bcd_valid_o, 1);
    check("sat.tens",  bus.tens_o, 9);
    check("sat.units", bus.units_o, 9);
    over_p();
    check("sat.high", bus.high_score_o, 99);

    // Asynchronous reset in the middle of a conversion
    start_p();
    while (m_score < 35) apple_p();
    tick(0, 1, 0, 0);
    check("arst.busy", bus.bcd_valid_o, 0);
    #2;
    reset_n = 1'b0;
    bus.start_i = 0; bus.apple_hit_i = 0; bus.bonus_hit_i = 0; bus.game_over_i = 0;
    #1;
    check_reset_values("arst");
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // High score / new record across three games
    play_game(12);
    check("g1.high", bus.high_score_o, 12);
    check("g1.rec",  bus.new_record_o, 1);
    play_game(12);
    check("g2.high", bus.high_score_o, 12);
    check("g2.rec",  bus.new_record_o, 0);
    play_game(15);
    check("g3.high", bus.high_score_o, 15);
    check("g3.rec",  bus.new_record_o, 1);

    // Blink in OVER with score 7, high 15
    start_p();
    repeat (7) apple_p();
    tick(0, 0, 0, 1);
    check("blink.entry", bus.show_high_o, 0);
    idle(3);
    check("blink.c3", bus.show_high_o, 0);
    idle(1);
    check("blink.c4", bus.show_high_o, 1);
    idle(3);
    check("blink.hvalid", bus.bcd_valid_o, 1);
    check("blink.htens",  bus.tens_o, 1);
    check("blink.hunits", bus.units_o, 5);
    idle(1);
    check("blink.c8", bus.show_high_o, 0);
    idle(3);
    check("blink.stens",  bus.tens_o, 0);
    check("blink.sunits", bus.units_o, 7);

    // game_over and apple edges together at 20
    start_p();
    while (m_score < 20) apple_p();
    tick(0, 1, 0, 1);
    check("goa.state", bus.state_o, 2);
    check("goa.score", bus.score_o, 20);
    check("goa.high",  bus.high_score_o, 20);
    check("goa.rec",   bus.new_record_o, 1);
    tick(0, 0, 0, 0);

    // Randomized request levels
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
